// File: rtl/ddr_arb_pkg.sv
// Shared types and round-robin helper for the DDR port arbiter.
package ddr_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_DATA
  } rd_state_t;

  typedef enum logic {
    WR_IDLE,
    WR_REQ
  } wr_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr+1, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= n) pos = pos - n;
      if (k <= n && !res.found && req[IDX_W'(pos)]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(pos);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr_select.sv
// Combinational round-robin index selector over NUM_REQ request lines.
module rr_select
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found_c,
  output logic [IDX_W-1:0]   idx_c
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
  end

  assign found_c = pick.found;
  assign idx_c   = pick.idx;

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR read channel and one DDR write channel among NUM_REQ cores
// with independent round-robin arbitration; read grants span the whole burst.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        core_rd_req,
  input  logic [NUM_REQ*ADDR_W-1:0] core_rd_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  core_rd_len,
  output logic [NUM_REQ-1:0]        core_rd_grant,
  output logic [DATA_W-1:0]         core_rd_data,
  output logic [NUM_REQ-1:0]        core_rd_valid,
  input  logic [NUM_REQ-1:0]        core_wr_req,
  input  logic [NUM_REQ*ADDR_W-1:0] core_wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] core_wr_data,
  output logic [NUM_REQ-1:0]        core_wr_grant,
  output logic                      ddr_read_req,
  output logic [ADDR_W-1:0]         ddr_read_addr,
  output logic [LEN_W-1:0]          ddr_read_len,
  input  logic                      ddr_read_grant,
  input  logic [DATA_W-1:0]         ddr_read_data,
  input  logic                      ddr_read_valid,
  output logic                      ddr_write_req,
  output logic [ADDR_W-1:0]         ddr_write_addr,
  output logic [DATA_W-1:0]         ddr_write_data,
  input  logic                      ddr_write_grant,
  output logic                      rd_busy,
  output logic                      stray_valid_err
);

  rd_state_t        rd_state;
  wr_state_t        wr_state;
  logic [IDX_W-1:0] rr_rd_ptr;
  logic [IDX_W-1:0] rr_wr_ptr;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_sel;
  logic [IDX_W-1:0] wr_sel;
  logic             rd_found;
  logic             wr_found;
  logic [LEN_W-1:0] beats_left;
  logic [LEN_W-1:0] sel_len;
  logic             rd_accept;
  logic             rd_beat;
  logic             wr_accept;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rd_sel (
    .req     (core_rd_req),
    .ptr     (rr_rd_ptr),
    .found_c (rd_found),
    .idx_c   (rd_sel)
  );

  rr_select #(.NUM_REQ(NUM_REQ)) u_wr_sel (
    .req     (core_wr_req),
    .ptr     (rr_wr_ptr),
    .found_c (wr_found),
    .idx_c   (wr_sel)
  );

  // A beat is routed with the grant itself or at any time during RD_DATA.
  assign rd_accept = (rd_state == RD_REQ) && ddr_read_grant;
  assign rd_beat   = ddr_read_valid && (rd_accept || (rd_state == RD_DATA));
  assign wr_accept = (wr_state == WR_REQ) && ddr_write_grant;
  assign sel_len   = core_rd_len[32'(rd_sel)*LEN_W +: LEN_W];

  assign core_rd_grant = rd_accept ? (NUM_REQ'(1) << rd_idx) : '0;
  assign core_rd_valid = rd_beat   ? (NUM_REQ'(1) << rd_idx) : '0;
  assign core_rd_data  = rd_beat   ? ddr_read_data : '0;
  assign core_wr_grant = wr_accept ? (NUM_REQ'(1) << wr_idx) : '0;
  assign rd_busy       = (rd_state != RD_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state        <= RD_IDLE;
      rr_rd_ptr       <= IDX_W'(NUM_REQ - 1);
      rd_idx          <= '0;
      ddr_read_req    <= 1'b0;
      ddr_read_addr   <= '0;
      ddr_read_len    <= '0;
      beats_left      <= '0;
      stray_valid_err <= 1'b0;
    end else begin
      if (ddr_read_valid && !rd_beat) stray_valid_err <= 1'b1;
      case (rd_state)
        RD_IDLE: begin
          if (rd_found) begin
            rd_idx        <= rd_sel;
            ddr_read_addr <= core_rd_addr[32'(rd_sel)*ADDR_W +: ADDR_W];
            ddr_read_len  <= (sel_len == '0) ? LEN_W'(1) : sel_len;
            ddr_read_req  <= 1'b1;
            rd_state      <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (ddr_read_grant) begin
            ddr_read_req <= 1'b0;
            if (ddr_read_valid && ddr_read_len == LEN_W'(1)) begin
              beats_left <= '0;
              rr_rd_ptr  <= rd_idx;
              rd_state   <= RD_IDLE;
            end else begin
              beats_left <= ddr_read_valid ? ddr_read_len - LEN_W'(1) : ddr_read_len;
              rd_state   <= RD_DATA;
            end
          end
        end
        RD_DATA: begin
          if (ddr_read_valid) begin
            beats_left <= beats_left - LEN_W'(1);
            if (beats_left == LEN_W'(1)) begin
              rr_rd_ptr <= rd_idx;
              rd_state  <= RD_IDLE;
            end
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state       <= WR_IDLE;
      rr_wr_ptr      <= IDX_W'(NUM_REQ - 1);
      wr_idx         <= '0;
      ddr_write_req  <= 1'b0;
      ddr_write_addr <= '0;
      ddr_write_data <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (wr_found) begin
            wr_idx         <= wr_sel;
            ddr_write_addr <= core_wr_addr[32'(wr_sel)*ADDR_W +: ADDR_W];
            ddr_write_data <= core_wr_data[32'(wr_sel)*DATA_W +: DATA_W];
            ddr_write_req  <= 1'b1;
            wr_state       <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (ddr_write_grant) begin
            ddr_write_req <= 1'b0;
            rr_wr_ptr     <= wr_idx;
            wr_state      <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule
